victim_buffer: RTL and testbench

- Multi-entry dirty-line writeback buffer placed between the D$ and the AHB cache-bus interface.
- Dirty victims are pushed in one cycle, so a line fill can start before the eviction reaches memory.
- Entries drain in FIFO order as multi-beat bus write bursts.
- Generalises the single-line writeback path to NUMENTRIES lines, with address lookup and a flush-drain mode.

---
 rtl/victim_buffer_pkg.sv | 19 +
 rtl/victim_buffer_match.sv | 44 ++++
 rtl/victim_buffer.sv | 143 ++++++++++++++
 tb/tb_victim_buffer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/victim_buffer_pkg.sv
// Shared types and default geometry for the dirty-line victim buffer.
// Optional feature macro: VICTIM_BUFFER_FORWARD_EN (see victim_buffer.sv).
package victim_buffer_pkg;

    typedef enum logic {
        VB_IDLE  = 1'b0,
        VB_WRITE = 1'b1
    } vbstate_t;

    localparam int PA_BITS_DEF    = 56;
    localparam int LINELEN_DEF    = 512;
    localparam int BEATLEN_DEF    = 64;
    localparam int NUMENTRIES_DEF = 4;

    localparam int LOGNE     = $clog2(NUMENTRIES_DEF);
    localparam int LOGBPL    = $clog2(LINELEN_DEF / BEATLEN_DEF);
    localparam int OFFSETLEN = $clog2(LINELEN_DEF / 8);

endpackage

// File: rtl/victim_buffer_match.sv
// Per-entry line-address comparators with a youngest-first one-hot select.
// Age is measured backwards from the tail pointer, so tail-1 is the newest entry.
module victim_buffer_match
    import victim_buffer_pkg::*;
#(
    parameter int NUMENTRIES = NUMENTRIES_DEF,
    parameter int TAGW       = PA_BITS_DEF - OFFSETLEN,
    parameter int PTRW       = LOGNE
) (
    input  logic [NUMENTRIES-1:0][TAGW-1:0] entryAdr,
    input  logic [NUMENTRIES-1:0]           entryValid,
    input  logic [PTRW-1:0]                 tailPtr,
    input  logic [TAGW-1:0]                 lookupTag,
    output logic                            lookupMatch,
    output logic [NUMENTRIES-1:0]           lineSel
);

    logic [NUMENTRIES-1:0] hit_s;
    logic                  found_s;
    logic [PTRW-1:0]       idx_s;

    // Raw per-entry hits on valid entries.
    always_comb begin
        hit_s = {NUMENTRIES{1'b0}};
        for (int i = 0; i < NUMENTRIES; i++) begin
            hit_s[i] = entryValid[i] & (entryAdr[i] == lookupTag);
        end
    end

    assign lookupMatch = |hit_s;

    // Walk from the newest entry to the oldest; the first hit owns the select.
    always_comb begin
        lineSel = {NUMENTRIES{1'b0}};
        found_s = 1'b0;
        idx_s   = tailPtr;
        for (int k = 1; k <= NUMENTRIES; k++) begin
            idx_s          = tailPtr - PTRW'(k);
            lineSel[idx_s] = hit_s[idx_s] & ~found_s;
            found_s        = found_s | hit_s[idx_s];
        end
    end

endmodule

// File: rtl/victim_buffer.sv
// Multi-entry dirty-line writeback FIFO draining as bus write bursts.
// Define VICTIM_BUFFER_FORWARD_EN to forward the youngest matching line on LookupLine.
module victim_buffer
    import victim_buffer_pkg::*;
#(
    parameter int PA_BITS    = PA_BITS_DEF,
    parameter int LINELEN    = LINELEN_DEF,
    parameter int BEATLEN    = BEATLEN_DEF,
    parameter int NUMENTRIES = NUMENTRIES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               EvictValid,
    input  logic [PA_BITS-1:0] EvictAdr,
    input  logic [LINELEN-1:0] EvictLine,
    output logic               EvictReady,
    input  logic [PA_BITS-1:0] LookupAdr,
    output logic               LookupMatch,
    output logic [LINELEN-1:0] LookupLine,
    output logic               BusWriteReq,
    output logic [PA_BITS-1:0] BusAdr,
    output logic [BEATLEN-1:0] BusWriteData,
    input  logic               BusBeatAck,
    input  logic               FlushReq,
    output logic               FlushDone,
    output logic               Empty,
    output logic               Full
);

    localparam int PTRW  = $clog2(NUMENTRIES);
    localparam int BEATS = LINELEN / BEATLEN;
    localparam int BEATW = $clog2(BEATS);
    localparam int OFFW  = $clog2(LINELEN / 8);
    localparam int TAGW  = PA_BITS - OFFW;

    logic [PTRW-1:0]                     headPtr_r, tailPtr_r;
    logic [PTRW:0]                       count_r;
    logic [BEATW-1:0]                    beatCount_r;
    vbstate_t                            state_r, stateNext_s;
    logic [NUMENTRIES-1:0][TAGW-1:0]     adrMem_r;
    logic [NUMENTRIES-1:0][LINELEN-1:0]  lineMem_r;
    logic [NUMENTRIES-1:0]               entryValid_s, lineSel_s;
    logic [BEATS-1:0][BEATLEN-1:0]       headBeats_s;
    logic full_s, empty_s, push_s, pop_s, lastBeat_s, unusedOffset_s;

    assign full_s     = (count_r == (PTRW+1)'(NUMENTRIES));
    assign empty_s    = (count_r == (PTRW+1)'(0));
    assign push_s     = EvictValid & ~full_s;
    assign lastBeat_s = (beatCount_r == BEATW'(BEATS - 1));
    assign pop_s      = (state_r == VB_WRITE) & BusBeatAck & lastBeat_s;

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            headPtr_r <= {PTRW{1'b0}};
            tailPtr_r <= {PTRW{1'b0}};
            count_r   <= {(PTRW+1){1'b0}};
        end else begin
            if (push_s) tailPtr_r <= tailPtr_r + PTRW'(1);
            if (pop_s)  headPtr_r <= headPtr_r + PTRW'(1);
            count_r <= count_r + {{PTRW{1'b0}}, push_s} - {{PTRW{1'b0}}, pop_s};
        end
    end

    // Entry storage; the head is safe because a push is refused while full.
    always_ff @(posedge clk) begin
        if (push_s) begin
            adrMem_r[tailPtr_r]  <= EvictAdr[PA_BITS-1:OFFW];
            lineMem_r[tailPtr_r] <= EvictLine;
        end
    end

    // Drain state register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= VB_IDLE;
        else       state_r <= stateNext_s;
    end

    // Drain next-state: IDLE always lasts one cycle between bursts.
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            VB_IDLE:  if (!empty_s) stateNext_s = VB_WRITE; else stateNext_s = VB_IDLE;
            VB_WRITE: if (pop_s)    stateNext_s = VB_IDLE;  else stateNext_s = VB_WRITE;
            default:  stateNext_s = VB_IDLE;
        endcase
    end

    // Beat counter within the current burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            beatCount_r <= {BEATW{1'b0}};
        end else if ((state_r == VB_WRITE) && BusBeatAck) begin
            beatCount_r <= lastBeat_s ? {BEATW{1'b0}} : beatCount_r + BEATW'(1);
        end
    end

    // An entry is valid when its distance from the head is below the count.
    always_comb begin
        entryValid_s = {NUMENTRIES{1'b0}};
        for (int i = 0; i < NUMENTRIES; i++) begin
            entryValid_s[i] = ({1'b0, PTRW'(PTRW'(i) - headPtr_r)} < count_r);
        end
    end

    victim_buffer_match #(
        .NUMENTRIES (NUMENTRIES),
        .TAGW       (TAGW),
        .PTRW       (PTRW)
    ) u_match (
        .entryAdr    (adrMem_r),
        .entryValid  (entryValid_s),
        .tailPtr     (tailPtr_r),
        .lookupTag   (LookupAdr[PA_BITS-1:OFFW]),
        .lookupMatch (LookupMatch),
        .lineSel     (lineSel_s)
    );

`ifdef VICTIM_BUFFER_FORWARD_EN
    // One-hot forwarding mux.
    always_comb begin
        LookupLine = {LINELEN{1'b0}};
        for (int i = 0; i < NUMENTRIES; i++) begin
            LookupLine = LookupLine | ({LINELEN{lineSel_s[i]}} & lineMem_r[i]);
        end
    end
`else
    logic unusedSel_s;
    assign unusedSel_s = ^lineSel_s;
    assign LookupLine  = {LINELEN{1'b0}};
`endif

    assign unusedOffset_s = ^{EvictAdr[OFFW-1:0], LookupAdr[OFFW-1:0]};
    assign headBeats_s    = lineMem_r[headPtr_r];
    assign BusWriteData   = headBeats_s[beatCount_r];
    assign BusAdr         = {adrMem_r[headPtr_r], {OFFW{1'b0}}};
    assign BusWriteReq    = (state_r == VB_WRITE);
    assign EvictReady     = ~full_s;
    assign Empty          = empty_s;
    assign Full           = full_s;
    assign FlushDone      = FlushReq & empty_s;

endmodule

// File: tb/tb_victim_buffer.sv
// Self-checking bench for victim_buffer: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_victim_buffer;

    localparam int BEATS = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         EvictValid;
    logic [55:0]  EvictAdr;
    logic [511:0] EvictLine;
    logic         EvictReady;
    logic [55:0]  LookupAdr;
    logic         LookupMatch;
    logic [511:0] LookupLine;
    logic         BusWriteReq;
    logic [55:0]  BusAdr;
    logic [63:0]  BusWriteData;
    logic         BusBeatAck;
    logic         FlushReq;
    logic         FlushDone;
    logic         Empty;
    logic         Full;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of pending lines, oldest first.
    logic [55:0]  mAdr[$];
    logic [511:0] mLine[$];
    bit           mReq  = 1'b0;
    int           mBeat = 0;

    victim_buffer dut (
        .clk(clk), .reset(reset),
        .EvictValid(EvictValid), .EvictAdr(EvictAdr), .EvictLine(EvictLine),
        .EvictReady(EvictReady),
        .LookupAdr(LookupAdr), .LookupMatch(LookupMatch), .LookupLine(LookupLine),
        .BusWriteReq(BusWriteReq), .BusAdr(BusAdr), .BusWriteData(BusWriteData),
        .BusBeatAck(BusBeatAck),
        .FlushReq(FlushReq), .FlushDone(FlushDone),
        .Empty(Empty), .Full(Full)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] randLine();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic bit expMatch(input logic [55:0] a);
        for (int i = 0; i < mAdr.size(); i++)
            if (mAdr[i][55:6] == a[55:6]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [511:0] expLine(input logic [55:0] a);
        logic [511:0] r = 512'd0;
`ifdef VICTIM_BUFFER_FORWARD_EN
        for (int i = 0; i < mAdr.size(); i++)
            if (mAdr[i][55:6] == a[55:6]) r = mLine[i];
`endif
        return r;
    endfunction

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic modelUpdate();
        int sz;
        bit push;
        if (reset) begin
            mAdr.delete(); mLine.delete(); mReq = 1'b0; mBeat = 0;
            return;
        end
        sz   = mAdr.size();
        push = EvictValid && (sz < 4);
        if (mReq) begin
            if (BusBeatAck) begin
                if (mBeat == BEATS - 1) begin
                    mAdr.delete(0); mLine.delete(0); mReq = 1'b0; mBeat = 0;
                end else begin
                    mBeat++;
                end
            end
        end else if (sz > 0) begin
            mReq = 1'b1;
        end
        if (push) begin
            mAdr.push_back({EvictAdr[55:6], 6'd0});
            mLine.push_back(EvictLine);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
    endtask

    task automatic idleInputs();
        EvictValid = 1'b0; EvictAdr = 56'd0; EvictLine = 512'd0;
        LookupAdr = 56'd0; BusBeatAck = 1'b0; FlushReq = 1'b0;
    endtask

    task automatic drainQuiet();
        idleInputs();
        BusBeatAck = 1'b1;
        for (int i = 0; i < 200 && mAdr.size() > 0; i++) tick();
        BusBeatAck = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idleInputs();
        tick(); tick();
        reset = 1'b0;
        #1;
        checks++; if (EvictReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", EvictReady); end
        checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", Empty); end
        checks++; if (Full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", Full); end
        checks++; if (BusWriteReq !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", BusWriteReq); end
        checks++; if (LookupMatch !== 1'b0) begin errors++; $display("FAIL reset_match: got %b want 0", LookupMatch); end
        checks++; if (FlushDone !== 1'b0) begin errors++; $display("FAIL reset_flushdone_lo: got %b want 0", FlushDone); end
        FlushReq = 1'b1;
        #1;
        checks++; if (FlushDone !== 1'b1) begin errors++; $display("FAIL reset_flushdone_hi: got %b want 1", FlushDone); end
        FlushReq = 1'b0;
        tick();
    endtask

    task automatic test_single_push();
        logic [511:0] line = randLine();
        EvictValid = 1'b1; EvictAdr = 56'h8000_0040; EvictLine = line;
        #1;
        tick();
        idleInputs();
        #1;
        checks++; if (BusWriteReq !== 1'b0 || Empty !== 1'b0) begin
            errors++; $display("FAIL single_idle: req=%b empty=%b want req=0 empty=0", BusWriteReq, Empty); end
        tick();
        for (int b = 0; b < BEATS; b++) begin
            BusBeatAck = 1'b1;
            #1;
            checks++; if (BusWriteReq !== 1'b1) begin errors++; $display("FAIL single_req beat%0d: got %b want 1", b, BusWriteReq); end
            checks++; if (BusAdr !== 56'h8000_0040) begin errors++; $display("FAIL single_adr: got %h want 80000040", BusAdr); end
            checks++; if (BusWriteData !== line[b*64 +: 64]) begin
                errors++; $display("FAIL single_data beat%0d: got %h want %h", b, BusWriteData, line[b*64 +: 64]); end
            tick();
        end
        BusBeatAck = 1'b0;
        #1;
        checks++; if (Empty !== 1'b1 || BusWriteReq !== 1'b0) begin
            errors++; $display("FAIL single_done: empty=%b req=%b want empty=1 req=0", Empty, BusWriteReq); end
        tick();
    endtask

    task automatic test_fill_full();
        logic [55:0] order[5];
        int burst = 0;
        bit accepted = 1'b0;
        for (int i = 0; i < 5; i++) order[i] = 56'h2000 + 56'(i * 64);
        for (int i = 0; i < 4; i++) begin
            EvictValid = 1'b1; EvictAdr = order[i]; EvictLine = randLine();
            #1; tick();
        end
        EvictAdr = order[4]; EvictLine = randLine();
        #1;
        checks++; if (Full !== 1'b1 || EvictReady !== 1'b0) begin
            errors++; $display("FAIL full_flags: full=%b ready=%b want full=1 ready=0", Full, EvictReady); end
        BusBeatAck = 1'b1;
        for (int c = 0; c < 300 && (mAdr.size() > 0 || !accepted); c++) begin
            #1;
            checks++; if (EvictReady !== (mAdr.size() < 4)) begin
                errors++; $display("FAIL full_ready: got %b want %b", EvictReady, mAdr.size() < 4); end
            if (mReq && mBeat == 0) begin
                checks++; if (BusAdr !== order[burst]) begin
                    errors++; $display("FAIL full_order burst%0d: got %h want %h", burst, BusAdr, order[burst]); end
                burst++;
            end
            if (EvictValid && mAdr.size() < 4) accepted = 1'b1;
            tick();
            if (accepted) EvictValid = 1'b0;
        end
        checks++; if (burst != 5) begin errors++; $display("FAIL full_bursts: got %0d want 5", burst); end
        idleInputs();
        tick();
    endtask

    task automatic test_lookup_dup();
        logic [511:0] d1 = randLine();
        logic [511:0] d2 = randLine();
        logic [511:0] want;
        EvictValid = 1'b1; EvictAdr = 56'h1000; EvictLine = d1;
        #1; tick();
        EvictLine = d2;
        #1; tick();
        idleInputs();
        LookupAdr = 56'h1010;
        #1;
`ifdef VICTIM_BUFFER_FORWARD_EN
        want = d2;
`else
        want = 512'd0;
`endif
        checks++; if (LookupMatch !== 1'b1) begin errors++; $display("FAIL dup_match: got %b want 1", LookupMatch); end
        checks++; if (LookupLine !== want) begin errors++; $display("FAIL dup_line: got %h want %h", LookupLine, want); end
        BusBeatAck = 1'b1;
        for (int c = 0; c < 60; c++) begin
            #1;
            checks++; if (LookupMatch !== expMatch(LookupAdr)) begin
                errors++; $display("FAIL dup_drain_match c%0d: got %b want %b", c, LookupMatch, expMatch(LookupAdr)); end
            checks++; if (LookupLine !== expLine(LookupAdr)) begin
                errors++; $display("FAIL dup_drain_line c%0d: got %h want %h", c, LookupLine, expLine(LookupAdr)); end
            tick();
            if (mAdr.size() == 0) break;
        end
        #1;
        checks++; if (LookupMatch !== 1'b0) begin errors++; $display("FAIL dup_after: got %b want 0", LookupMatch); end
        idleInputs();
        tick();
    endtask

    task automatic test_flush();
        int c;
        for (int i = 0; i < 3; i++) begin
            EvictValid = 1'b1; EvictAdr = 56'h6000 + 56'(i * 64); EvictLine = randLine();
            #1; tick();
        end
        idleInputs();
        FlushReq = 1'b1;
        for (c = 0; c < 300 && mAdr.size() > 0; c++) begin
            BusBeatAck = c[0];
            #1;
            checks++; if (FlushDone !== 1'b0) begin errors++; $display("FAIL flush_early c%0d: got %b want 0", c, FlushDone); end
            tick();
        end
        if (mAdr.size() > 0) begin errors++; $display("FAIL flush_timeout: %0d entries left", mAdr.size()); end
        BusBeatAck = 1'b0;
        #1;
        checks++; if (FlushDone !== 1'b1) begin errors++; $display("FAIL flush_done: got %b want 1", FlushDone); end
        idleInputs();
        tick();
    endtask

    task automatic test_reset_midburst();
        logic [511:0] line = randLine();
        bit hit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            EvictValid = 1'b1; EvictAdr = 56'h7000 + 56'(i * 64); EvictLine = randLine();
            #1; tick();
        end
        idleInputs();
        BusBeatAck = 1'b1;
        for (int c = 0; c < 20 && !hit; c++) begin
            if (mReq && mBeat == 3) begin hit = 1'b1; reset = 1'b1; end
            #1; tick();
        end
        if (!hit) begin errors++; $display("FAIL midreset_timeout: beat 3 not reached"); end
        reset = 1'b0;
        BusBeatAck = 1'b0;
        #1;
        checks++; if (BusWriteReq !== 1'b0 || Empty !== 1'b1 || EvictReady !== 1'b1) begin
            errors++; $display("FAIL midreset_flags: req=%b empty=%b ready=%b want 0 1 1", BusWriteReq, Empty, EvictReady); end
        EvictValid = 1'b1; EvictAdr = 56'h7400; EvictLine = line;
        #1; tick();
        idleInputs();
        #1; tick();
        #1;
        checks++; if (BusWriteReq !== 1'b1 || BusWriteData !== line[63:0]) begin
            errors++; $display("FAIL midreset_beat0: req=%b data=%h want 1 %h", BusWriteReq, BusWriteData, line[63:0]); end
        drainQuiet();
    endtask

    task automatic test_back_to_back();
        logic [511:0] newLine = randLine();
        logic [55:0]  order[3];
        int burst = 0;
        bit hit = 1'b0;
        order[0] = 56'h4000; order[1] = 56'h4040; order[2] = 56'h4080;
        for (int i = 0; i < 2; i++) begin
            EvictValid = 1'b1; EvictAdr = order[i]; EvictLine = randLine();
            #1; tick();
        end
        idleInputs();
        BusBeatAck = 1'b1;
        for (int c = 0; c < 300 && mAdr.size() > 0; c++) begin
            if (mReq && mBeat == 7 && !hit) begin
                hit = 1'b1; EvictValid = 1'b1; EvictAdr = order[2]; EvictLine = newLine;
            end
            #1;
            if (mReq) begin
                if (mBeat == 0) begin
                    checks++; if (BusAdr !== order[burst]) begin
                        errors++; $display("FAIL b2b_order burst%0d: got %h want %h", burst, BusAdr, order[burst]); end
                    burst++;
                end
                checks++; if (BusWriteData !== mLine[0][mBeat*64 +: 64]) begin
                    errors++; $display("FAIL b2b_data beat%0d: got %h want %h", mBeat, BusWriteData, mLine[0][mBeat*64 +: 64]); end
                if (burst == 3) begin
                    checks++; if (BusWriteData !== newLine[mBeat*64 +: 64]) begin
                        errors++; $display("FAIL b2b_newline beat%0d: got %h", mBeat, BusWriteData); end
                end
            end
            tick();
            if (EvictValid) begin
                EvictValid = 1'b0;
                #1;
                checks++; if (Empty !== 1'b0 || Full !== 1'b0 || mAdr.size() != 2) begin
                    errors++; $display("FAIL b2b_count: empty=%b full=%b model=%0d want 0 0 2", Empty, Full, mAdr.size()); end
            end
        end
        checks++; if (burst != 3) begin errors++; $display("FAIL b2b_bursts: got %0d want 3", burst); end
        idleInputs();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            EvictValid = ($urandom_range(0, 2) == 0);
            EvictAdr   = 56'h5000 + 56'($urandom_range(0, 3) * 64) + 56'($urandom_range(0, 63));
            EvictLine  = randLine();
            BusBeatAck = $urandom_range(0, 1) == 1;
            FlushReq   = ($urandom_range(0, 3) == 0);
            LookupAdr  = 56'h5000 + 56'($urandom_range(0, 4) * 64) + 56'($urandom_range(0, 63));
            #1;
            checks++; if (EvictReady !== (mAdr.size() < 4)) begin errors++; $display("FAIL rnd_ready c%0d: got %b", c, EvictReady); end
            checks++; if (Empty !== (mAdr.size() == 0)) begin errors++; $display("FAIL rnd_empty c%0d: got %b", c, Empty); end
            checks++; if (Full !== (mAdr.size() == 4)) begin errors++; $display("FAIL rnd_full c%0d: got %b", c, Full); end
            checks++; if (BusWriteReq !== mReq) begin errors++; $display("FAIL rnd_req c%0d: got %b want %b", c, BusWriteReq, mReq); end
            checks++; if (FlushDone !== (FlushReq && mAdr.size() == 0)) begin errors++; $display("FAIL rnd_flushdone c%0d: got %b", c, FlushDone); end
            checks++; if (LookupMatch !== expMatch(LookupAdr)) begin
                errors++; $display("FAIL rnd_match c%0d: got %b want %b", c, LookupMatch, expMatch(LookupAdr)); end
            checks++; if (LookupLine !== expLine(LookupAdr)) begin
                errors++; $display("FAIL rnd_line c%0d: got %h want %h", c, LookupLine, expLine(LookupAdr)); end
            if (mReq) begin
                checks++; if (BusAdr !== mAdr[0]) begin errors++; $display("FAIL rnd_adr c%0d: got %h want %h", c, BusAdr, mAdr[0]); end
                checks++; if (BusWriteData !== mLine[0][mBeat*64 +: 64]) begin
                    errors++; $display("FAIL rnd_data c%0d: got %h want %h", c, BusWriteData, mLine[0][mBeat*64 +: 64]); end
            end
            tick();
        end
        drainQuiet();
    endtask

    initial begin
        reset = 1'b1;
        idleInputs();
        @(negedge clk);
        test_reset();
        test_single_push();
        test_fill_full();
        test_lookup_dup();
        test_flush();
        test_reset_midburst();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
